// File: rtl/display_ctrl.sv
// display_ctrl: two-requester LED matrix frame controller.
// Arbitrates round-robin between requesters A and B, captures the granted
// frame into a registered buffer, enables the scanner until it reports done,
// then holds off for REFRESH cycles before rescanning.
// Optional feature macro: DISPLAY_CTRL_TIMEOUT_EN adds a scan watchdog that
// aborts a scan after 4*GS cycles without a done pulse and raises sticky err_o.
module display_ctrl #(
  parameter int GS      = 8,
  parameter int REFRESH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_a_i,
  input  logic [GS*GS-1:0] frame_a_i,
  input  logic             req_b_i,
  input  logic [GS*GS-1:0] frame_b_i,
  output logic             gnt_a_o,
  output logic             gnt_b_o,
  input  logic             d_disp_i,
  output logic             e_disp_o,
  output logic [GS*GS-1:0] matrix_o,
  output logic             busy_o,
  output logic [7:0]       frame_cnt_o,
  output logic             err_o
);

  localparam int N = GS * GS;
  // HOLD counts down from REFRESH-1 to 0, giving exactly REFRESH cycles.
  localparam logic [7:0] HOLD_LOAD = 8'(REFRESH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t       state_reg, state_next;
  logic [7:0]   hold_cnt_reg, hold_cnt_next;
  logic         prio_b_reg, prio_b_next;
  logic         gnt_a_next, gnt_b_next;
  logic         e_disp_next, busy_next;
  logic [N-1:0] matrix_next;
  logic [N-1:0] grant_frame;
  logic [7:0]   frame_cnt_next;
  logic         grant_window;
  logic         pick_a, pick_b;
  logic         scan_done;
  logic         scan_timeout;

  // Arbitration: grants only outside SCAN, and never in the cycle a grant
  // pulse is already showing, so a requester that drops its request on
  // seeing the pulse is not granted twice.
  always_comb begin
    grant_window = (state_reg != ST_SCAN) && !gnt_a_o && !gnt_b_o;
    pick_a       = grant_window && req_a_i && (!req_b_i || !prio_b_reg);
    pick_b       = grant_window && req_b_i && !pick_a;
  end

  // Frame selected for capture, assembled row by row.
  genvar gi;
  generate
    for (gi = 0; gi < GS; gi++) begin : g_row
      assign grant_frame[gi*GS +: GS] = pick_b ? frame_b_i[gi*GS +: GS]
                                               : frame_a_i[gi*GS +: GS];
    end
  endgenerate

  assign scan_done = (state_reg == ST_SCAN) && d_disp_i;

`ifdef DISPLAY_CTRL_TIMEOUT_EN
  localparam int            TW      = $clog2(4 * GS);
  localparam logic [TW-1:0] TO_LAST = TW'(4 * GS - 1);

  logic [TW-1:0] scan_cnt_reg;
  logic          err_reg;

  // A done pulse on the final allowed cycle still counts as a normal finish.
  assign scan_timeout = (state_reg == ST_SCAN) && !d_disp_i &&
                        (scan_cnt_reg == TO_LAST);

  // Number of cycles already spent in the current scan.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      scan_cnt_reg <= '0;
    else if (state_reg == ST_SCAN && state_next == ST_SCAN)
      scan_cnt_reg <= scan_cnt_reg + TW'(1);
    else
      scan_cnt_reg <= '0;
  end

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      err_reg <= 1'b0;
    else if (scan_timeout)
      err_reg <= 1'b1;
  end

  assign err_o = err_reg;
`else
  assign scan_timeout = 1'b0;
  assign err_o        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic: IDLE leaves on the edge after its first grant pulse.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (gnt_a_o || gnt_b_o)          state_next = ST_SCAN;
      ST_SCAN: if (scan_done || scan_timeout)    state_next = ST_HOLD;
      ST_HOLD: if (hold_cnt_reg == 8'd0)         state_next = ST_SCAN;
      default:                                   state_next = ST_IDLE;
    endcase
  end

  // Output and datapath next values, all registered below.
  always_comb begin
    e_disp_next    = (state_next == ST_SCAN);
    busy_next      = (state_next == ST_SCAN);
    gnt_a_next     = pick_a;
    gnt_b_next     = pick_b;
    matrix_next    = (pick_a || pick_b) ? grant_frame : matrix_o;
    frame_cnt_next = scan_done ? frame_cnt_o + 8'd1 : frame_cnt_o;
    prio_b_next    = pick_a ? 1'b1 : (pick_b ? 1'b0 : prio_b_reg);
    hold_cnt_next  = hold_cnt_reg;
    if (state_reg == ST_SCAN && state_next == ST_HOLD)
      hold_cnt_next = HOLD_LOAD;
    else if (state_reg == ST_HOLD && hold_cnt_reg != 8'd0)
      hold_cnt_next = hold_cnt_reg - 8'd1;
  end

  // Output, buffer and bookkeeping registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_a_o      <= 1'b0;
      gnt_b_o      <= 1'b0;
      e_disp_o     <= 1'b0;
      busy_o       <= 1'b0;
      matrix_o     <= '0;
      frame_cnt_o  <= 8'd0;
      prio_b_reg   <= 1'b0;
      hold_cnt_reg <= 8'd0;
    end else begin
      gnt_a_o      <= gnt_a_next;
      gnt_b_o      <= gnt_b_next;
      e_disp_o     <= e_disp_next;
      busy_o       <= busy_next;
      matrix_o     <= matrix_next;
      frame_cnt_o  <= frame_cnt_next;
      prio_b_reg   <= prio_b_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

endmodule

// File: tb/tb_display_ctrl.sv
// tb_display_ctrl: self-checking bench for display_ctrl (GS=8, REFRESH=16).
// Directed table vectors and sequences for the corner cases, then a random
// run compared cycle by cycle against a behavioural model.
module tb_display_ctrl;

  localparam int GS      = 8;
  localparam int REFRESH = 16;
  localparam int N       = GS * GS;
`ifdef DISPLAY_CTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [63:0] FA = 64'h8142_2418_1824_4281;
  localparam logic [63:0] FB = 64'h0F0F_F0F0_3C3C_C3C3;
  localparam logic [63:0] F3 = 64'hDEAD_BEEF_0123_4567;

  localparam int M_IDLE = 0;
  localparam int M_SCAN = 1;
  localparam int M_HOLD = 2;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         req_a_i = 1'b0;
  logic         req_b_i = 1'b0;
  logic         d_disp_i = 1'b0;
  logic [N-1:0] frame_a_i = '0;
  logic [N-1:0] frame_b_i = '0;
  logic         gnt_a_o, gnt_b_o, e_disp_o, busy_o, err_o;
  logic [N-1:0] matrix_o;
  logic [7:0]   frame_cnt_o;

  int checks   = 0;
  int failures = 0;

  display_ctrl #(.GS(GS), .REFRESH(REFRESH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_a_i     (req_a_i),
    .frame_a_i   (frame_a_i),
    .req_b_i     (req_b_i),
    .frame_b_i   (frame_b_i),
    .gnt_a_o     (gnt_a_o),
    .gnt_b_o     (gnt_b_o),
    .d_disp_i    (d_disp_i),
    .e_disp_o    (e_disp_o),
    .matrix_o    (matrix_o),
    .busy_o      (busy_o),
    .frame_cnt_o (frame_cnt_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          ra;
    bit          rb;
    logic [63:0] fa;
    logic [63:0] fb;
    bit          ega;
    bit          egb;
    logic [63:0] em;
  } vec_t;

  vec_t vecs[4];

  // Behavioural model state.
  int          m_mode;
  bit          m_gnt_a, m_gnt_b, m_err, m_prefer_b;
  logic [63:0] m_matrix;
  int          m_frames, m_hold_left, m_scan_age;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset;
    req_a_i = 1'b0; req_b_i = 1'b0; d_disp_i = 1'b0;
    frame_a_i = '0; frame_b_i = '0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Grant A from IDLE and step into the first SCAN cycle.
  task automatic start_scan(input logic [63:0] f);
    req_a_i = 1'b1; frame_a_i = f;
    tick;
    req_a_i = 1'b0;
    tick;
  endtask

  task automatic wait_edisp(input string name);
    int n = 0;
    while (e_disp_o !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    chk1(name, e_disp_o, 1'b1);
  endtask

  task automatic model_reset;
    m_mode = M_IDLE; m_gnt_a = 0; m_gnt_b = 0; m_err = 0; m_prefer_b = 0;
    m_matrix = '0; m_frames = 0; m_hold_left = 0; m_scan_age = 0;
  endtask

  // One clock edge of the behavioural model, from the rules of the block.
  task automatic model_step(input bit ra, input bit rb, input bit d,
                            input logic [63:0] fa, input logic [63:0] fb);
    bit can, ga, gb;
    can = (m_mode != M_SCAN) && !m_gnt_a && !m_gnt_b;
    ga  = can && ra && (!rb || !m_prefer_b);
    gb  = can && rb && !ga;
    case (m_mode)
      M_IDLE: if (m_gnt_a || m_gnt_b) begin m_mode = M_SCAN; m_scan_age = 0; end
      M_SCAN: begin
        m_scan_age++;
        if (d) begin
          m_frames = (m_frames + 1) % 256;
          m_mode = M_HOLD; m_hold_left = REFRESH;
        end else if (TO_EN && m_scan_age == 4 * GS) begin
          m_err = 1; m_mode = M_HOLD; m_hold_left = REFRESH;
        end
      end
      default: begin
        if (m_hold_left == 1) begin m_mode = M_SCAN; m_scan_age = 0; end
        else m_hold_left--;
      end
    endcase
    if (ga) begin m_matrix = fa; m_prefer_b = 1; end
    if (gb) begin m_matrix = fb; m_prefer_b = 0; end
    m_gnt_a = ga;
    m_gnt_b = gb;
  endtask

  initial begin
    int n_grant, low, scan_age;
    bit prev_busy, pa, pb, e;

    vecs[0] = '{1'b1, 1'b0, FA, FB, 1'b1, 1'b0, FA};
    vecs[1] = '{1'b0, 1'b1, FA, FB, 1'b0, 1'b1, FB};
    vecs[2] = '{1'b1, 1'b1, FA, FB, 1'b1, 1'b0, FA};
    vecs[3] = '{1'b0, 1'b0, FA, FB, 1'b0, 1'b0, 64'h0};

    // Reset state.
    do_reset;
    chk1("rst_e_disp", e_disp_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk("rst_matrix", matrix_o, 64'h0);
    chk("rst_frame_cnt", 64'(frame_cnt_o), 64'h0);
    chk1("rst_err", err_o, 1'b0);
    $display("reset state checked");

    // Table: first grant from IDLE on the first edge after reset release.
    for (int i = 0; i < 4; i++) begin
      do_reset;
      req_a_i = vecs[i].ra; req_b_i = vecs[i].rb;
      frame_a_i = vecs[i].fa; frame_b_i = vecs[i].fb;
      tick;
      req_a_i = 1'b0; req_b_i = 1'b0;
      chk1($sformatf("vec%0d_gnt_a", i), gnt_a_o, vecs[i].ega);
      chk1($sformatf("vec%0d_gnt_b", i), gnt_b_o, vecs[i].egb);
      chk($sformatf("vec%0d_matrix", i), matrix_o, vecs[i].em);
      chk1($sformatf("vec%0d_e_disp", i), e_disp_o, 1'b0);
      $display("vec %0d ra=%0d rb=%0d gnt_a=%0d gnt_b=%0d", i, vecs[i].ra, vecs[i].rb, gnt_a_o, gnt_b_o);
    end

    // First frame, scan of 9 cycles, then REFRESH-long hold.
    do_reset;
    req_a_i = 1'b1; frame_a_i = FA;
    tick;
    req_a_i = 1'b0;
    chk1("first_gnt_a", gnt_a_o, 1'b1);
    chk("first_matrix", matrix_o, FA);
    chk1("first_e_disp_low", e_disp_o, 1'b0);
    tick;
    chk1("first_e_disp_high", e_disp_o, 1'b1);
    chk1("first_gnt_a_pulse", gnt_a_o, 1'b0);
    chk1("first_busy", busy_o, 1'b1);
    repeat (8) tick;
    chk1("scan_still_on", e_disp_o, 1'b1);
    d_disp_i = 1'b1;
    tick;
    d_disp_i = 1'b0;
    chk("scan_frame_cnt", 64'(frame_cnt_o), 64'd1);
    chk1("scan_e_disp_off", e_disp_o, 1'b0);
    chk1("scan_busy_off", busy_o, 1'b0);
    low = 0;
    while (e_disp_o == 1'b0 && low < 100) begin
      low++;
      d_disp_i = (low == 3);
      tick;
    end
    d_disp_i = 1'b0;
    chk("hold_length", 64'(low), 64'(REFRESH));
    chk("hold_ignores_done", 64'(frame_cnt_o), 64'd1);
    $display("scan done: frame_cnt=%0d hold_cycles=%0d", frame_cnt_o, low);

    // Round-robin with both requests held.
    do_reset;
    frame_a_i = FA; frame_b_i = FB; req_a_i = 1'b1; req_b_i = 1'b1;
    n_grant = 0; prev_busy = 1'b0; scan_age = 0;
    for (int c = 0; c < 60; c++) begin
      tick;
      if (gnt_a_o || gnt_b_o) begin
        chk1("arb_not_from_scan", prev_busy, 1'b0);
        chk1("arb_one_hot", gnt_a_o & gnt_b_o, 1'b0);
        chk1($sformatf("arb_grant%0d_is_a", n_grant), gnt_a_o, n_grant % 2 == 0);
        chk($sformatf("arb_grant%0d_matrix", n_grant), matrix_o, (n_grant % 2 == 0) ? FA : FB);
        $display("arb grant %0d to %s", n_grant, gnt_a_o ? "A" : "B");
        n_grant++;
      end
      d_disp_i = e_disp_o && scan_age == 4;
      scan_age = e_disp_o ? scan_age + 1 : 0;
      prev_busy = busy_o;
    end
    req_a_i = 1'b0; req_b_i = 1'b0; d_disp_i = 1'b0;
    chk1("arb_enough_grants", n_grant >= 6, 1'b1);

    // Grant in the last HOLD cycle, then done+request together in SCAN.
    do_reset;
    start_scan(FA);
    d_disp_i = 1'b1;
    tick;
    d_disp_i = 1'b0;
    chk("last_hold_cnt1", 64'(frame_cnt_o), 64'd1);
    repeat (REFRESH - 1) tick;
    chk1("last_hold_still_low", e_disp_o, 1'b0);
    req_b_i = 1'b1; frame_b_i = FB;
    tick;
    req_b_i = 1'b0;
    chk1("last_hold_gnt_b", gnt_b_o, 1'b1);
    chk("last_hold_matrix", matrix_o, FB);
    chk1("last_hold_scan", e_disp_o, 1'b1);
    $display("last hold cycle grant: gnt_b=%0d matrix=%0h", gnt_b_o, matrix_o);
    tick;
    d_disp_i = 1'b1; req_a_i = 1'b1; frame_a_i = F3;
    tick;
    d_disp_i = 1'b0;
    chk1("pend_no_gnt", gnt_a_o, 1'b0);
    chk1("pend_e_disp", e_disp_o, 1'b0);
    chk("pend_matrix_kept", matrix_o, FB);
    chk("pend_cnt2", 64'(frame_cnt_o), 64'd2);
    tick;
    req_a_i = 1'b0;
    chk1("pend_gnt_in_hold", gnt_a_o, 1'b1);
    chk("pend_matrix_new", matrix_o, F3);
    $display("pending request granted in first hold cycle: gnt_a=%0d", gnt_a_o);

    // Frame counter wraps after 256 scans.
    do_reset;
    req_a_i = 1'b1; frame_a_i = FA;
    tick;
    req_a_i = 1'b0;
    for (int s = 1; s <= 256; s++) begin
      wait_edisp($sformatf("wrap_scan%0d_start", s));
      d_disp_i = 1'b1;
      tick;
      d_disp_i = 1'b0;
      if (s == 1)   chk("wrap_cnt1", 64'(frame_cnt_o), 64'd1);
      if (s == 255) chk("wrap_cnt255", 64'(frame_cnt_o), 64'd255);
    end
    chk("wrap_cnt0", 64'(frame_cnt_o), 64'd0);
    $display("wrap: frame_cnt=%0d after 256 scans", frame_cnt_o);

    // Scan watchdog.
    do_reset;
    start_scan(FA);
    if (TO_EN) begin
      repeat (30) tick;
      chk1("to_cycle31_err", err_o, 1'b0);
      tick;
      chk1("to_cycle32_err", err_o, 1'b0);
      chk1("to_cycle32_scan", e_disp_o, 1'b1);
      tick;
      chk1("to_err_set", err_o, 1'b1);
      chk1("to_e_disp_off", e_disp_o, 1'b0);
      chk("to_cnt_unchanged", 64'(frame_cnt_o), 64'd0);
      repeat (20) tick;
      chk1("to_err_sticky", err_o, 1'b1);
    end else begin
      repeat (200) tick;
      chk1("nto_err_zero", err_o, 1'b0);
      chk1("nto_still_scanning", e_disp_o, 1'b1);
      chk("nto_cnt", 64'(frame_cnt_o), 64'd0);
    end
    $display("watchdog: err=%0d e_disp=%0d", err_o, e_disp_o);

    // Reset in the middle of a scan.
    do_reset;
    start_scan(FA);
    repeat (3) tick;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk1("midrst_e_disp", e_disp_o, 1'b0);
    chk("midrst_matrix", matrix_o, 64'h0);
    chk1("midrst_busy", busy_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (4) tick;
    chk1("midrst_idle_e_disp", e_disp_o, 1'b0);
    chk1("midrst_idle_gnt", gnt_a_o | gnt_b_o, 1'b0);
    req_a_i = 1'b1; frame_a_i = FB;
    tick;
    req_a_i = 1'b0;
    chk1("midrst_regrant", gnt_a_o, 1'b1);
    tick;
    chk1("midrst_rescan", e_disp_o, 1'b1);
    $display("mid-scan reset recovered: e_disp=%0d", e_disp_o);

    // Random traffic against the behavioural model.
    do_reset;
    model_reset;
    pa = 0; pb = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pa && $urandom_range(0, 3) == 0) begin pa = 1; frame_a_i = {$urandom, $urandom}; end
      if (!pb && $urandom_range(0, 3) == 0) begin pb = 1; frame_b_i = {$urandom, $urandom}; end
      req_a_i = pa; req_b_i = pb;
      d_disp_i = ($urandom_range(0, 5) == 0);
      @(posedge clk_i);
      model_step(req_a_i, req_b_i, d_disp_i, frame_a_i, frame_b_i);
      @(negedge clk_i);
      e = (m_mode == M_SCAN);
      chk($sformatf("rand%0d_ctrl", c),
          64'({gnt_a_o, gnt_b_o, e_disp_o, busy_o, err_o, frame_cnt_o}),
          64'({m_gnt_a, m_gnt_b, e, e, m_err, 8'(m_frames)}));
      chk($sformatf("rand%0d_matrix", c), matrix_o, m_matrix);
      if (m_gnt_a || m_gnt_b)
        $display("rand cycle %0d grant %s frames=%0d", c, m_gnt_a ? "A" : "B", m_frames);
      if (m_gnt_a) pa = 0;
      if (m_gnt_b) pb = 0;
    end
    req_a_i = 1'b0; req_b_i = 1'b0; d_disp_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
